uart_recv: RTL and testbench

UART receiver that sits directly downstream of the UART transmit stage. It shares the transmitter's configuration inputs, so a looped-back `uart_txd` decodes cleanly.
- Synchronises `uart_rxd` and detects the start bit.
- Samples every bit at mid-period.
- Checks optional parity and 1-4 stop bits.
- Emits a one-cycle `rx_valid` with right-aligned data and error flags, to the APB/FIFO layer above.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_recv.sv | 204 ++++++++++++++++++++
 tb/tb_uart_recv.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// baud/100 divisor table used by both the transmit and receive stages.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CHECK,
    STOP
  } uart_rx_state_t;

  localparam logic [1:0] CHK_NONE = 2'b00;
  localparam logic [1:0] CHK_ODD  = 2'b01;
  localparam logic [1:0] CHK_EVEN = 2'b10;

  // Unused code 7 falls back to 9600 baud.
  function automatic int unsigned bps_div(input logic [2:0] bps_mode);
    case (bps_mode)
      3'd0:    return 96;
      3'd1:    return 192;
      3'd2:    return 384;
      3'd3:    return 1152;
      3'd4:    return 2304;
      3'd5:    return 4608;
      3'd6:    return 9216;
      default: return 96;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial input plus a delay flop that yields a
// single-cycle falling-edge strobe on the synchronised line.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rxd,
  output logic rxd_s,
  output logic rxd_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q, dly_d;

  always_comb begin
    meta_d = rxd;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  // Idle-high reset so a line that is already high never looks like an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rxd_s    = sync_q;
  assign rxd_fall = dly_q & ~sync_q;

endmodule

// File: rtl/uart_recv.sv
// UART receiver: mid-bit sampling of start, 1..16 data bits (first bit lands
// in the MSB of the field), optional parity and 1..4 stop bits.
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  bps_mode,
  input  logic [3:0]  data_num,
  input  logic [1:0]  check_mode,
  input  logic [1:0]  stop_num,
  input  logic        uart_rxd,
  output logic        uart_rx_busy,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  output logic        parity_err,
  output logic        frame_err
);

  logic rxd_s;
  logic rxd_fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (uart_rxd),
    .rxd_s    (rxd_s),
    .rxd_fall (rxd_fall)
  );

  uart_rx_state_t state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [2:0]  cfg_bps_q, cfg_bps_d;
  logic [3:0]  cfg_dnum_q, cfg_dnum_d;
  logic [1:0]  cfg_chk_q, cfg_chk_d;
  logic [1:0]  cfg_stop_q, cfg_stop_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic        rx_valid_q, rx_valid_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;

  // Per-mode bit-period counts resolve to constants at elaboration.
  logic [15:0] bps_cnt_tbl [8];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bps
      assign bps_cnt_tbl[gi] = 16'(CLK_FREQ / bps_div(3'(gi)) / 100);
    end
  endgenerate

  logic [15:0] bps_cnt;
  logic [15:0] half_cnt;
  logic        full_hit;
  logic        half_hit;
  logic        par_en;
  logic        par_exp;

  assign bps_cnt  = bps_cnt_tbl[cfg_bps_q];
  assign half_cnt = (bps_cnt + 16'd1) >> 1;
  assign full_hit = (timer_q == bps_cnt);
  assign half_hit = (timer_q == half_cnt - 16'd1);

  always_comb begin
    case (cfg_chk_q)
      CHK_ODD:  par_en = 1'b1;
      CHK_EVEN: par_en = 1'b1;
      CHK_NONE: par_en = 1'b0;
      default:  par_en = 1'b0;
    endcase
    par_exp = (cfg_chk_q == CHK_ODD) ? ~^shift_q : ^shift_q;
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 16'd1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    cfg_bps_d    = cfg_bps_q;
    cfg_dnum_d   = cfg_dnum_q;
    cfg_chk_d    = cfg_chk_q;
    cfg_stop_d   = cfg_stop_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    busy_d       = busy_q;
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        timer_d = 16'd0;
        if (rxd_fall) begin
          state_d    = START;
          cfg_bps_d  = bps_mode;
          cfg_dnum_d = data_num;
          cfg_chk_d  = check_mode;
          cfg_stop_d = stop_num;
        end
      end
      START: begin
        if (half_hit) begin
          timer_d = 16'd0;
          if (!rxd_s) begin
            state_d   = DATA;
            busy_d    = 1'b1;
            bit_cnt_d = 4'd0;
            shift_d   = 16'd0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (full_hit) begin
          timer_d   = 16'd0;
          shift_d   = {shift_q[14:0], rxd_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == cfg_dnum_q) begin
            bit_cnt_d = 4'd0;
            state_d   = par_en ? CHECK : STOP;
          end
        end
      end
      CHECK: begin
        if (full_hit) begin
          timer_d   = 16'd0;
          bit_cnt_d = 4'd0;
          state_d   = STOP;
          if (rxd_s != par_exp) perr_d = 1'b1;
        end
      end
      STOP: begin
        if (full_hit) begin
          timer_d   = 16'd0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (!rxd_s) ferr_d = 1'b1;
          // Leave at mid-stop so an immediately following start edge is seen.
          if (bit_cnt_q[1:0] == cfg_stop_q) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_q | ~rxd_s;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      timer_q      <= 16'd0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 16'd0;
      cfg_bps_q    <= 3'd0;
      cfg_dnum_q   <= 4'd0;
      cfg_chk_q    <= 2'd0;
      cfg_stop_q   <= 2'd0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      busy_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 16'd0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      cfg_bps_q    <= cfg_bps_d;
      cfg_dnum_q   <= cfg_dnum_d;
      cfg_chk_q    <= cfg_chk_d;
      cfg_stop_q   <= cfg_stop_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      busy_q       <= busy_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign uart_rx_busy = busy_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: a behavioural serial driver feeds frames, a monitor logs
// every rx_valid, and a scoreboard derives data/flags/timing from frame rules.
module tb_uart_recv;

  // Reduced clock keeps the all-baud sweep short while exercising every mode.
  localparam int TB_CLK = 2000000;

  typedef struct {
    logic [15:0] data;
    logic        perr;
    logic        ferr;
    int          cyc;
  } rx_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  bps_mode;
  logic [3:0]  data_num;
  logic [1:0]  check_mode;
  logic [1:0]  stop_num;
  logic        uart_rxd;
  logic        uart_rx_busy;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        parity_err;
  logic        frame_err;

  always #5 clk = ~clk;

  uart_recv #(.CLK_FREQ(TB_CLK)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bps_mode     (bps_mode),
    .data_num     (data_num),
    .check_mode   (check_mode),
    .stop_num     (stop_num),
    .uart_rxd     (uart_rxd),
    .uart_rx_busy (uart_rx_busy),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  obs_n = 0;
  int  busy_cycles = 0;
  int  rd = 0;
  rx_t obs_arr [512];
  rx_t exp_q [$];
  logic busy_mid;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uart_rx_busy) busy_cycles <= busy_cycles + 1;
    if (rx_valid) begin
      obs_arr[obs_n] <= '{data: rx_data, perr: parity_err, ferr: frame_err, cyc: cyc};
      obs_n <= obs_n + 1;
      $display("rx_valid cyc=%0d data=%04h parity_err=%0b frame_err=%0b", cyc, rx_data, parity_err, frame_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int period_of(input int bps);
    int tbl [8];
    tbl = '{96, 192, 384, 1152, 2304, 4608, 9216, 96};
    return TB_CLK / tbl[bps] / 100 + 1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int p);
    uart_rxd = b;
    repeat (p) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int dnum, input int chk, input int stp, input int bps);
    bps_mode   = 3'(bps);
    data_num   = 4'(dnum);
    check_mode = 2'(chk);
    stop_num   = 2'(stp);
  endtask

  // Transmits one frame MSB-of-field first; config inputs are scrambled after
  // the start bit since the receiver must work from its latched copy.
  task automatic drive_frame(input logic [15:0] data, input int dnum, input int chk, input int stp,
                             input int bps, input bit flip_par, input int bad_stop, output int start_c);
    int p;
    logic [16:0] mask;
    logic par;
    p = period_of(bps);
    mask = (17'd1 << (dnum + 1)) - 17'd1;
    set_cfg(dnum, chk, stp, bps);
    start_c = cyc;
    drive_bit(1'b0, p);
    bps_mode   = 3'($urandom);
    data_num   = 4'($urandom);
    check_mode = 2'($urandom);
    stop_num   = 2'($urandom);
    for (int i = dnum; i >= 0; i--) begin
      drive_bit(data[i], p);
      if (i == dnum) busy_mid = uart_rx_busy;
    end
    if (chk == 1 || chk == 2) begin
      par = ($countones(data & mask[15:0]) % 2) == 1;
      if (chk == 1) par = ~par;
      drive_bit(par ^ flip_par, p);
    end
    for (int s = 0; s <= stp; s++) drive_bit((s == bad_stop) ? 1'b0 : 1'b1, p);
    uart_rxd = 1'b1;
  endtask

  task automatic push_exp(input logic [15:0] data, input int dnum, input int chk, input int stp,
                          input int bps, input bit perr, input bit ferr, input int start_c);
    int p, half, idx;
    logic [16:0] mask;
    p    = period_of(bps);
    half = p >> 1;
    idx  = 1 + (dnum + 1) + ((chk == 1 || chk == 2) ? 1 : 0) + stp;
    mask = (17'd1 << (dnum + 1)) - 17'd1;
    exp_q.push_back('{data: data & mask[15:0], perr: perr, ferr: ferr, cyc: start_c + half + idx * p + 1});
  endtask

  task automatic check_frames(input string tag);
    rx_t e, o;
    for (int i = 0; i < 64 && (obs_n - rd) < exp_q.size(); i++) @(negedge clk);
    check({tag, "_count"}, obs_n - rd, exp_q.size());
    while (exp_q.size() > 0 && rd < obs_n) begin
      e = exp_q.pop_front();
      o = obs_arr[rd];
      rd++;
      check({tag, "_data"}, o.data, e.data);
      check({tag, "_parity_err"}, o.perr, e.perr);
      check({tag, "_frame_err"}, o.ferr, e.ferr);
      check_range({tag, "_latency"}, o.cyc - e.cyc, -2, 2);
    end
    exp_q.delete();
    rd = obs_n;
    @(posedge clk);
    #1;
    check({tag, "_busy_idle"}, uart_rx_busy, 1'b0);
  endtask

  initial begin
    int sc, sc2, p, b0, n0, dnum, stp;
    logic [15:0] d;

    rstn = 1'b0;
    uart_rxd = 1'b1;
    busy_mid = 1'b0;
    set_cfg(7, 0, 0, 3);
    idle(3);
    check("rst_busy", uart_rx_busy, 1'b0);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 16'h0000);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    rstn = 1'b1;
    idle(5);

    // 8N1 byte with latency check
    drive_frame(16'h00A5, 7, 0, 0, 3, 1'b0, -1, sc);
    check("s1_busy_mid", busy_mid, 1'b1);
    push_exp(16'h00A5, 7, 0, 0, 3, 1'b0, 1'b0, sc);
    idle(2);
    check_frames("s1");

    // Even parity with a wrong parity bit
    drive_frame(16'h005A, 7, 2, 0, 3, 1'b1, -1, sc);
    push_exp(16'h005A, 7, 2, 0, 3, 1'b1, 1'b0, sc);
    idle(2);
    check_frames("s2");

    // Back-to-back 16-bit odd-parity frames, two stop bits
    drive_frame(16'hBEEF, 15, 1, 1, 3, 1'b0, -1, sc);
    drive_frame(16'h1234, 15, 1, 1, 3, 1'b0, -1, sc2);
    push_exp(16'hBEEF, 15, 1, 1, 3, 1'b0, 1'b0, sc);
    push_exp(16'h1234, 15, 1, 1, 3, 1'b0, 1'b0, sc2);
    idle(2);
    check_frames("s3");

    // Second of three stop bits low
    d = 16'($urandom_range(0, 255));
    drive_frame(d, 7, 0, 2, 3, 1'b0, 1, sc);
    push_exp(d, 7, 0, 2, 3, 1'b0, 1'b1, sc);
    idle(2);
    check_frames("s4");

    // Short low glitch must be rejected
    p = period_of(3);
    set_cfg(7, 0, 0, 3);
    b0 = busy_cycles;
    n0 = obs_n;
    uart_rxd = 1'b0;
    idle((p >> 1) - 4);
    uart_rxd = 1'b1;
    idle(3 * p);
    check("glitch_busy", busy_cycles - b0, 0);
    check("glitch_no_valid", obs_n - n0, 0);
    rd = obs_n;

    // Break: one frame of zeros with frame_err, then silent until line rises and falls
    set_cfg(7, 0, 0, 3);
    sc = cyc;
    uart_rxd = 1'b0;
    idle(12 * p);
    uart_rxd = 1'b1;
    push_exp(16'h0000, 7, 0, 0, 3, 1'b0, 1'b1, sc);
    idle(2);
    check_frames("brk");
    drive_frame(16'h0081, 7, 0, 0, 3, 1'b0, -1, sc);
    push_exp(16'h0081, 7, 0, 0, 3, 1'b0, 1'b0, sc);
    idle(2);
    check_frames("post_brk");

    // Reset during a data bit aborts the frame
    n0 = obs_n;
    fork
      drive_frame(16'h00C3, 7, 0, 0, 3, 1'b0, -1, sc);
      begin
        idle(4 * p + p / 2);
        check("s5_busy_before_rst", uart_rx_busy, 1'b1);
        rstn = 1'b0;
        #1;
        check("s5_rst_busy", uart_rx_busy, 1'b0);
        check("s5_rst_valid", rx_valid, 1'b0);
        check("s5_rst_data", rx_data, 16'h0000);
        check("s5_rst_parity_err", parity_err, 1'b0);
        check("s5_rst_frame_err", frame_err, 1'b0);
      end
    join
    idle(3);
    rstn = 1'b1;
    idle(3);
    check("s5_no_valid", obs_n - n0, 0);
    rd = obs_n;
    drive_frame(16'h003C, 7, 0, 0, 3, 1'b0, -1, sc);
    push_exp(16'h003C, 7, 0, 0, 3, 1'b0, 1'b0, sc);
    idle(2);
    check_frames("s5_clean");

    // Sweep of all baud modes, field widths and parity modes with random data
    for (int bps = 0; bps < 7; bps++) begin
      for (int di = 0; di < 3; di++) begin
        dnum = (di == 0) ? 4 : ((di == 1) ? 7 : 15);
        for (int chk = 0; chk < 3; chk++) begin
          d   = 16'($urandom);
          stp = $urandom_range(0, 3);
          drive_frame(d, dnum, chk, stp, bps, 1'b0, -1, sc);
          push_exp(d, dnum, chk, stp, bps, 1'b0, 1'b0, sc);
          idle(2);
          check_frames($sformatf("sweep_b%0d_n%0d_c%0d", bps, dnum, chk));
        end
      end
    end

    // Single data bit, parity code 3 (none), baud code 7 (9600), four stop bits
    drive_frame(16'h0001, 0, 3, 3, 7, 1'b0, -1, sc);
    push_exp(16'h0001, 0, 3, 3, 7, 1'b0, 1'b0, sc);
    idle(2);
    check_frames("edge_n0_c3_b7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
